// File: rtl/lim_ctrl_pkg.sv
// lim_ctrl_pkg: shared types and the opcode decoder for the Logic-in-Memory
// register controller.
//   OP_W        opcode width
//   op_e        opcode encoding
//   lim_ctl_t   control bits for the LiMDff primitive
//   lim_dec_t   decoder result: control bits plus an illegal-opcode flag
//   lock_st_e   lock FSM states
package lim_ctrl_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_LOADN = 4'd2,
    OP_AND   = 4'd3,
    OP_NAND  = 4'd4,
    OP_OR    = 4'd5,
    OP_NOR   = 4'd6,
    OP_XOR   = 4'd7,
    OP_XNOR  = 4'd8
  } op_e;

  // force_en: load the operand instead of combining with the stored value.
  // invert:   complement the result of the selected function.
  // nand_sel: base function NAND; nxor_sel: base function XNOR; neither: NOR.
  typedef struct packed {
    logic force_en;
    logic invert;
    logic nand_sel;
    logic nxor_sel;
  } lim_ctl_t;

  typedef struct packed {
    lim_ctl_t ctl;
    logic     illegal;
  } lim_dec_t;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_e;

  // Unused (don't-care) control bits are driven to 0.
  // Illegal opcodes decode as NOP (OR with a zeroed operand).
  function automatic lim_dec_t lim_decode(input logic [OP_W-1:0] op);
    lim_dec_t r;
    r.ctl     = '{force_en: 1'b0, invert: 1'b1, nand_sel: 1'b0, nxor_sel: 1'b0};
    r.illegal = 1'b0;
    case (op_e'(op))
      OP_NOP:   r.ctl = '{force_en: 1'b0, invert: 1'b1, nand_sel: 1'b0, nxor_sel: 1'b0};
      OP_LOAD:  r.ctl = '{force_en: 1'b1, invert: 1'b0, nand_sel: 1'b0, nxor_sel: 1'b0};
      OP_LOADN: r.ctl = '{force_en: 1'b1, invert: 1'b1, nand_sel: 1'b0, nxor_sel: 1'b0};
      OP_AND:   r.ctl = '{force_en: 1'b0, invert: 1'b1, nand_sel: 1'b1, nxor_sel: 1'b0};
      OP_NAND:  r.ctl = '{force_en: 1'b0, invert: 1'b0, nand_sel: 1'b1, nxor_sel: 1'b0};
      OP_OR:    r.ctl = '{force_en: 1'b0, invert: 1'b1, nand_sel: 1'b0, nxor_sel: 1'b0};
      OP_NOR:   r.ctl = '{force_en: 1'b0, invert: 1'b0, nand_sel: 1'b0, nxor_sel: 1'b0};
      OP_XOR:   r.ctl = '{force_en: 1'b0, invert: 1'b1, nand_sel: 1'b0, nxor_sel: 1'b1};
      OP_XNOR:  r.ctl = '{force_en: 1'b0, invert: 1'b0, nand_sel: 1'b0, nxor_sel: 1'b1};
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/LiMDff.sv
// LiMDff: Logic-in-Memory register primitive. When enabled it replaces its
// content with f(q, d), where the function is chosen by the control bits:
//   force: base = d; otherwise base = NAND / XNOR / NOR of (q, d)
//   invert complements base.
//   clk_i, rst_i  clock, synchronous active-high reset (q -> RESET_VAL)
//   en_i          update enable
//   force_i, invert_i, nand_i, nxor_i  function select
//   d_i           operand
//   q_o           stored value
module LiMDff #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             force_i,
  input  logic             invert_i,
  input  logic             nand_i,
  input  logic             nxor_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    if (force_i)     base = d_i;
    else if (nand_i) base = ~(q_q & d_i);
    else if (nxor_i) base = ~(q_q ^ d_i);
    else             base = ~(q_q | d_i);
    q_d = invert_i ? ~base : base;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lim_rr_arb.sv
// lim_rr_arb: round-robin arbiter with an externally updated pointer.
//   clk_i, rst_i   clock, synchronous active-high reset (pointer -> 0)
//   valid_i        per-requester request
//   mask_i         per-requester enable (restricts grants while locked)
//   ptr_upd_i      load ptr_val_i into the pointer at the end of this cycle
//   ptr_val_i      new pointer value
//   grant_o        one-hot grant (zero when nothing eligible)
//   gnt_idx_o      index of the granted requester
//   gnt_any_o      a grant is issued this cycle
module lim_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  valid_i,
  input  logic [NREQ-1:0]  mask_i,
  input  logic             ptr_upd_i,
  input  logic [IDX_W-1:0] ptr_val_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [NREQ-1:0]  cand;

  // (p + k) mod NREQ without a divider; p < NREQ and k < NREQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDX_W'(s);
  endfunction

  assign cand = valid_i & mask_i;

  // First eligible requester at or above the pointer, wrapping around.
  always_comb begin
    grant_o   = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any_o && cand[wrap_add(ptr_q, k)]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = wrap_add(ptr_q, k);
      end
    end
    if (gnt_any_o) grant_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (ptr_upd_i) begin
      ptr_q <= ptr_val_i;
    end
  end

endmodule

// File: rtl/lim_reg_ctrl.sv
// lim_reg_ctrl: shares one LiMDff register among NREQ requesters.
// Ops are arbitrated round-robin (one accept per cycle); a requester may hold
// the register across several ops with req_lock, guarded by a watchdog.
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester request
//   req_op         4-bit opcode per requester (slice i = requester i)
//   req_data       operand per requester
//   req_lock       keep ownership after this op
//   req_ready      one-hot grant; accept = valid & ready
//   rsp_valid      one-cycle response strobe, cycle after accept
//   rsp_id         accepted requester
//   rsp_data       register value after the op
//   rsp_old        register value before the op
//   rsp_err        illegal opcode
//   lock_timeout   one-cycle pulse after a watchdog release
//   lim_q          current register value
module lim_reg_ctrl
  import lim_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NREQ         = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               LOCK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         rsp_old,
  output logic                     rsp_err,
  output logic                     lock_timeout,
  output logic [WIDTH-1:0]         lim_q
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(LOCK_TIMEOUT + 1);

  lock_st_e         state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             to_q, to_d;

  logic [NREQ-1:0]  arb_mask;
  logic [NREQ-1:0]  owner_oh;
  logic             ptr_upd;
  logic [IDX_W-1:0] ptr_val;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_data;
  logic             sel_lock;
  lim_dec_t         dec;
  logic [WIDTH-1:0] opnd;
  logic             lock_eff;
  logic             wd_expire;

  logic             rsp_valid_q;
  logic [IDX_W-1:0] rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_old_q;
  logic             rsp_err_q;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Same function the LiMDff applies; used to capture the post-op value
  // for the response in the accept cycle.
  function automatic logic [WIDTH-1:0] lim_eval(input lim_ctl_t c,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] base;
    if (c.force_en)      base = d;
    else if (c.nand_sel) base = ~(q & d);
    else if (c.nxor_sel) base = ~(q ^ d);
    else                 base = ~(q | d);
    return c.invert ? ~base : base;
  endfunction

  // While locked only the owner is eligible, even when it is idle.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end
  assign arb_mask = (state_q == ST_LOCKED) ? owner_oh : '1;

  lim_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (req_valid),
    .mask_i    (arb_mask),
    .ptr_upd_i (ptr_upd),
    .ptr_val_i (ptr_val),
    .grant_o   (grant),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = grant;

  // Granted request and its decode; NOP and illegal ops zero the operand
  // so the OR they decode to leaves the register unchanged.
  assign sel_op    = req_op[int'(gnt_idx)*OP_W +: OP_W];
  assign sel_data  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_lock  = req_lock[gnt_idx];
  assign dec       = lim_decode(sel_op);
  assign opnd      = (dec.illegal || sel_op == OP_NOP) ? '0 : sel_data;
  assign lock_eff  = sel_lock && !dec.illegal;
  assign wd_expire = (wd_q == WD_W'(LOCK_TIMEOUT - 1));

  LiMDff #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_lim (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (gnt_any),
    .force_i  (dec.ctl.force_en),
    .invert_i (dec.ctl.invert),
    .nand_i   (dec.ctl.nand_sel),
    .nxor_i   (dec.ctl.nxor_sel),
    .d_i      (opnd),
    .q_o      (lim_q)
  );

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      owner_q <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB: begin
        if (gnt_any && lock_eff) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (gnt_any) begin
          if (!lock_eff) state_d = ST_ARB;
        end else if (wd_expire) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Lock FSM: outputs (pointer update, owner, watchdog, timeout pulse).
  // The watchdog release happens in the idle cycle that brings the count
  // to LOCK_TIMEOUT; the owner is idle there, so nothing is accepted.
  always_comb begin
    ptr_upd = 1'b0;
    ptr_val = idx_inc(gnt_idx);
    owner_d = owner_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    case (state_q)
      ST_ARB: begin
        wd_d = '0;
        if (gnt_any) begin
          if (lock_eff) owner_d = gnt_idx;
          else          ptr_upd = 1'b1;
        end
      end
      ST_LOCKED: begin
        ptr_val = idx_inc(owner_q);
        if (gnt_any) begin
          wd_d = '0;
          if (!lock_eff) ptr_upd = 1'b1;
        end else if (wd_expire) begin
          wd_d    = '0;
          to_d    = 1'b1;
          ptr_upd = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Response register: one cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_old_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_any;
      rsp_err_q   <= gnt_any && dec.illegal;
      if (gnt_any) begin
        rsp_id_q   <= gnt_idx;
        rsp_old_q  <= lim_q;
        rsp_data_q <= lim_eval(dec.ctl, lim_q, opnd);
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_old      = rsp_old_q;
  assign rsp_err      = rsp_err_q;
  assign lock_timeout = to_q;

endmodule

// File: tb/tb_lim_reg_ctrl.sv
// Testbench for lim_reg_ctrl: directed stimulus, an opcode-level reference
// model checked every cycle, and hand-computed literal expectations.
module tb_lim_reg_ctrl;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LTO   = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [WIDTH-1:0]  rsp_data;
  logic [WIDTH-1:0]  rsp_old;
  logic              rsp_err;
  logic              lock_timeout;
  logic [WIDTH-1:0]  lim_q;

  int n_cmp = 0;
  int n_bad = 0;

  lim_reg_ctrl #(
    .WIDTH        (WIDTH),
    .NREQ         (NREQ),
    .RESET_VAL    (8'h00),
    .LOCK_TIMEOUT (LTO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_old      (rsp_old),
    .rsp_err      (rsp_err),
    .lock_timeout (lock_timeout),
    .lim_q        (lim_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (opcode semantics) ----------------
  function automatic logic [7:0] apply_op(input logic [3:0] op, input logic [7:0] r,
                                          input logic [7:0] d);
    case (op)
      4'd1:    return d;
      4'd2:    return ~d;
      4'd3:    return r & d;
      4'd4:    return ~(r & d);
      4'd5:    return r | d;
      4'd6:    return ~(r | d);
      4'd7:    return r ^ d;
      4'd8:    return ~(r ^ d);
      default: return r;
    endcase
  endfunction

  bit         m_init = 0;
  logic [7:0] m_reg;
  bit         m_locked;
  int         m_owner, m_ptr, m_idle;
  bit         e_rv, e_err, e_to;
  int         e_id;
  logic [7:0] e_old, e_data;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy;
    int g;
    logic [3:0] op;
    logic [7:0] d, nv;
    bit lk, legal;
    if (rst) begin
      m_init = 1; m_reg = 8'h00; m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
      e_rv = 0; e_err = 0; e_to = 0; e_id = 0; e_old = 0; e_data = 0;
    end else if (m_init) begin
      chk("m.rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("m.rsp_id",   32'(rsp_id),   32'(e_id));
        chk("m.rsp_old",  32'(rsp_old),  32'(e_old));
        chk("m.rsp_data", 32'(rsp_data), 32'(e_data));
      end
      chk("m.rsp_err",      32'(rsp_err),      32'(e_err));
      chk("m.lock_timeout", 32'(lock_timeout), 32'(e_to));
      chk("m.lim_q",        32'(lim_q),        32'(m_reg));
      e_rdy = '0;
      g = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      if (g >= 0) e_rdy[g] = 1'b1;
      chk("m.req_ready", 32'(req_ready), 32'(e_rdy));
      e_rv = 0; e_err = 0; e_to = 0;
      if (g >= 0) begin
        op = req_op[g*4 +: 4];
        d  = req_data[g*8 +: 8];
        lk = req_lock[g];
        legal = (op <= 4'd8);
        nv = apply_op(op, m_reg, d);
        e_rv = 1; e_id = g; e_old = m_reg; e_data = nv; e_err = !legal;
        m_reg = nv;
        if (lk && legal) begin
          m_locked = 1; m_owner = g; m_idle = 0;
        end else begin
          m_locked = 0; m_ptr = (g + 1) % NREQ;
        end
      end else if (m_locked) begin
        m_idle++;
        if (m_idle == LTO) begin
          m_locked = 0; m_ptr = (m_owner + 1) % NREQ; e_to = 1; m_idle = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_all();
    req_valid = '0; req_op = '0; req_data = '0; req_lock = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] d, input logic lk);
    req_valid[i]       = 1'b1;
    req_op[i*4 +: 4]   = op;
    req_data[i*8 +: 8] = d;
    req_lock[i]        = lk;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr_all();
    repeat (3) step();
    rst = 1'b0;

    // req0 LOAD 0xA5
    set_req(0, 4'd1, 8'hA5, 1'b0);
    smp();
    chk("rst.lim_q", 32'(lim_q), 32'h00);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.lock_timeout", 32'(lock_timeout), 32'h0);
    chk("load.ready", 32'(req_ready), 32'h1);
    step(); clr_all(); smp();
    chk("load.rsp_valid", 32'(rsp_valid), 32'h1);
    chk("load.rsp_id", 32'(rsp_id), 32'h0);
    chk("load.rsp_old", 32'(rsp_old), 32'h00);
    chk("load.rsp_data", 32'(rsp_data), 32'hA5);
    chk("load.lim_q", 32'(lim_q), 32'hA5);

    // req2 XOR 0xFF then NAND 0x0F back-to-back
    step(); set_req(2, 4'd7, 8'hFF, 1'b0); smp();
    chk("xor.ready", 32'(req_ready), 32'h4);
    step(); set_req(2, 4'd4, 8'h0F, 1'b0); smp();
    chk("xor.rsp_data", 32'(rsp_data), 32'h5A);
    chk("xor.rsp_old", 32'(rsp_old), 32'hA5);
    step(); clr_all(); smp();
    chk("nand.rsp_valid", 32'(rsp_valid), 32'h1);
    chk("nand.rsp_data", 32'(rsp_data), 32'hF5);
    chk("nand.rsp_old", 32'(rsp_old), 32'h5A);

    // req3 NOP alone moves the pointer to 0
    step(); set_req(3, 4'd0, 8'hFF, 1'b0); smp();
    chk("nop3.ready", 32'(req_ready), 32'h8);

    // all four NOP: grants rotate 0,1,2,3,0
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, 8'hFF, 1'b0);
    for (int n = 0; n < 5; n++) begin
      smp();
      chk("rr.ready", 32'(req_ready), 32'(1 << (n % 4)));
      chk("rr.lim_q", 32'(lim_q), 32'hF5);
      chk("rr.rsp_err", 32'(rsp_err), 32'h0);
      step();
    end

    // locked sequence by req1 with req0/req3 competing
    clr_all();
    set_req(0, 4'd0, 8'h00, 1'b0);
    set_req(3, 4'd0, 8'h00, 1'b0);
    set_req(1, 4'd1, 8'h3C, 1'b1);
    smp();
    chk("lock.ready0", 32'(req_ready), 32'h2);
    step(); set_req(1, 4'd3, 8'hF0, 1'b1); smp();
    chk("lock.ready1", 32'(req_ready), 32'h2);
    chk("lock.data0", 32'(rsp_data), 32'h3C);
    step(); set_req(1, 4'd5, 8'h01, 1'b0); smp();
    chk("lock.ready2", 32'(req_ready), 32'h2);
    chk("lock.data1", 32'(rsp_data), 32'h30);
    step(); req_valid[1] = 1'b0; smp();
    chk("lock.next_grant", 32'(req_ready), 32'h8);
    chk("lock.data2", 32'(rsp_data), 32'h31);
    step(); clr_all();

    // watchdog release: req2 locks, then goes idle
    set_req(2, 4'd1, 8'h11, 1'b1); smp();
    chk("wd.ready", 32'(req_ready), 32'h4);
    step(); clr_all(); set_req(0, 4'd0, 8'h00, 1'b0);
    for (int n = 0; n < LTO; n++) begin
      smp();
      chk("wd.idle_ready", 32'(req_ready), 32'h0);
      chk("wd.idle_to", 32'(lock_timeout), 32'h0);
      step();
    end
    smp();
    chk("wd.pulse", 32'(lock_timeout), 32'h1);
    chk("wd.grant0", 32'(req_ready), 32'h1);
    chk("wd.lim_q", 32'(lim_q), 32'h11);
    step(); clr_all(); smp();
    chk("wd.pulse_end", 32'(lock_timeout), 32'h0);

    // illegal opcode with lock requested: error, value unchanged, stays ARB
    step(); set_req(1, 4'hC, 8'hFF, 1'b1); smp();
    chk("ill.ready", 32'(req_ready), 32'h2);
    step(); clr_all(); set_req(0, 4'd0, 8'h00, 1'b0); smp();
    chk("ill.rsp_err", 32'(rsp_err), 32'h1);
    chk("ill.rsp_data", 32'(rsp_data), 32'h11);
    chk("ill.rsp_old", 32'(rsp_old), 32'h11);
    chk("ill.arb_grant", 32'(req_ready), 32'h1);
    step(); clr_all();

    // reset in the middle of a locked sequence
    set_req(1, 4'd1, 8'h77, 1'b1); smp();
    chk("mrst.ready", 32'(req_ready), 32'h2);
    step(); set_req(1, 4'd3, 8'h0F, 1'b1); rst = 1'b1; smp();
    chk("mrst.rsp_data", 32'(rsp_data), 32'h77);
    step(); rst = 1'b0; clr_all(); set_req(0, 4'd0, 8'h00, 1'b0); smp();
    chk("mrst.lim_q", 32'(lim_q), 32'h00);
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mrst.grant0", 32'(req_ready), 32'h1);
    step(); clr_all(); smp();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lim_reg_ctrl.md
Name: lim_reg_ctrl

Overview:
- Shares one Logic-in-Memory register, an instance of the existing LiMDff primitive, between NREQ requesters.
- Arbitrates per-cycle ops round-robin and decodes each 4-bit opcode to force/invert/nand/nxor controls.
- Returns the old and new register value one cycle after acceptance.
- Supports locked multi-op sequences with a watchdog.

Parameters:
- WIDTH, 8: register/operand width.
- NREQ, 4: number of requesters (>=2).
- RESET_VAL, 0: register value after reset.
- LOCK_TIMEOUT, 16: idle cycles before a held lock is forcibly released (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request.
- req_op  in  NREQ*4  opcode, slice i = requester i.
- req_data  in  NREQ*WIDTH  operand.
- req_lock  in  NREQ  1 = keep ownership after this op.
- req_ready  out  NREQ  one-hot grant; accept = valid&ready.
- rsp_valid  out  1  response strobe.
- rsp_id  out  $clog2(NREQ)  accepted requester.
- rsp_data  out  WIDTH  register value after op.
- rsp_old  out  WIDTH  register value before op.
- rsp_err  out  1  illegal opcode.
- lock_timeout  out  1  one-cycle pulse on watchdog release.
- lim_q  out  WIDTH  current register value.

Behaviour:
- Reset: lim_q=RESET_VAL, state ARB, rr pointer=0, all rsp_* = 0, lock_timeout=0, watchdog=0.
- Opcodes and control mapping (force, invert, nand, nxor):
  - 0 NOP: 0,1,0,0 with operand forced to 0, so OR with 0 holds the value.
  - 1 LOAD: 1,0,x,x.
  - 2 LOADN: 1,1,x,x.
  - 3 AND: 0,1,1,0.
  - 4 NAND: 0,0,1,0.
  - 5 OR: 0,1,0,0.
  - 6 NOR: 0,0,0,0.
  - 7 XOR: 0,1,0,1.
  - 8 XNOR: 0,0,0,1.
  - 9-15 illegal: decoded as NOP, rsp_err=1, treated as lock=0.
- Throughput and latency: at most one accept per cycle. The register updates at the end of the accept cycle t. rsp_* are valid in t+1 for exactly one cycle. Back-to-back accepts produce back-to-back responses. No backpressure on the response.
- req_ready is combinational from req_valid, state and pointer. It never asserts for a requester whose req_valid=0.
- ARB state:
  - Grant the first valid requester scanning from the pointer upward, with wrap.
  - On accept with lock=0: pointer = granted+1 mod NREQ.
  - On accept with lock=1 and a legal op: go to LOCKED, owner = granted, watchdog = 0.
- LOCKED state:
  - Only the owner can be granted; all other req_ready are 0 even if the owner is idle.
  - Owner accept with lock=1: stay LOCKED, watchdog = 0.
  - Owner accept with lock=0 or an illegal op: return to ARB, pointer = owner+1.
  - Each cycle without an owner accept increments the watchdog. On the cycle the watchdog reaches LOCK_TIMEOUT: lock_timeout=1 (registered, asserted next cycle), state ARB, pointer = owner+1. No op is accepted in the release cycle.
- Reset mid-sequence: drops the lock, discards any pending response, and restores RESET_VAL.
- rsp_old equals lim_q in the accept cycle. lim_q always equals the primitive's output.

Decomposition:
- Package lim_ctrl_pkg holds:
  - OP_W=4 and the op_e enum (values above).
  - lim_ctl_t struct {force, invert, nand, nxor}.
  - Function lim_decode(op) returning {lim_ctl_t, illegal}.
- Sub-module lim_rr_arb (NREQ): round-robin grant with pointer, a mask input for LOCKED, and a pointer-update input.
- The top holds the lock FSM, watchdog, LiMDff instance and response register.

Test Plan (WIDTH=8, NREQ=4, RESET_VAL=0, LOCK_TIMEOUT=4):
- Reset, then req0 LOAD 0xA5 -> next cycle rsp_valid=1, rsp_id=0, rsp_old=0x00, rsp_data=0xA5; lim_q=0xA5.
- req2 XOR 0xFF, then NAND 0x0F back-to-back -> rsp_data 0x5A then 0xF5 on consecutive cycles; rsp_old 0xA5 then 0x5A.
- All four valid with NOP continuously, pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; lim_q unchanged; rsp_err=0.
- With req0 and req3 also valid: req1 LOAD 0x3C lock=1, then AND 0xF0 lock=1, then OR 0x01 lock=0 -> rsp_data 0x3C, 0x30, 0x31; req_ready[0]=req_ready[3]=0 throughout; the next grant goes to req3.
- req2 LOAD 0x11 lock=1, then req2 deasserts valid while req0 stays valid -> lock_timeout pulses once, 4 idle cycles later; req0 is granted the following cycle; lim_q stays 0x11.
- req1 op 0xC data 0xFF -> rsp_err=1, rsp_data=rsp_old=unchanged; state remains ARB.
